// File: rtl/wm8731_pkg.sv
// rtl/wm8731_pkg.sv - WM8731 register map, init-table size, sequencer states and ACK timeout
package wm8731_pkg;

  localparam logic [6:0] REG_LINVOL  = 7'h00;
  localparam logic [6:0] REG_RINVOL  = 7'h01;
  localparam logic [6:0] REG_LHPOUT  = 7'h02;
  localparam logic [6:0] REG_RHPOUT  = 7'h03;
  localparam logic [6:0] REG_APATH   = 7'h04;
  localparam logic [6:0] REG_DPATH   = 7'h05;
  localparam logic [6:0] REG_PWRDN   = 7'h06;
  localparam logic [6:0] REG_IFACE   = 7'h07;
  localparam logic [6:0] REG_SRATE   = 7'h08;
  localparam logic [6:0] REG_ACTIVE  = 7'h09;
  localparam logic [6:0] REG_RESET   = 7'h0F;

  localparam int TABLE_LEN   = 11;
  localparam int ACK_TIMEOUT = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_REQ,
    S_ACK,
    S_BUSY,
    S_GAP,
    S_DONE,
    S_ERR
  } state_e;

  // WM8731 control words carry a 7-bit register address above 9 data bits.
  function automatic logic [15:0] reg_word(input logic [6:0] ra, input logic [8:0] data);
    return {ra, data};
  endfunction

endpackage

// File: rtl/wm8731_cfg_rom.sv
// rtl/wm8731_cfg_rom.sv - combinational WM8731 power-up table, {reg, data} per index
module wm8731_cfg_rom
  import wm8731_pkg::*;
(
  input  logic [3:0]  idx_i,
  output logic [15:0] word_o
);

  always_comb begin
    word_o = 16'h0000;
    case (idx_i)
      4'd0:    word_o = reg_word(REG_RESET,  9'h000);
      4'd1:    word_o = reg_word(REG_LINVOL, 9'h017);
      4'd2:    word_o = reg_word(REG_RINVOL, 9'h017);
      4'd3:    word_o = reg_word(REG_LHPOUT, 9'h079);
      4'd4:    word_o = reg_word(REG_RHPOUT, 9'h079);
      4'd5:    word_o = reg_word(REG_APATH,  9'h012);
      4'd6:    word_o = reg_word(REG_DPATH,  9'h000);
      4'd7:    word_o = reg_word(REG_PWRDN,  9'h000);
      4'd8:    word_o = reg_word(REG_IFACE,  9'h002);
      4'd9:    word_o = reg_word(REG_SRATE,  9'h000);
      4'd10:   word_o = reg_word(REG_ACTIVE, 9'h001);
      default: word_o = 16'h0000;
    endcase
  end

endmodule

// File: rtl/wm8731_cfg_seq.sv
// rtl/wm8731_cfg_seq.sv - WM8731 init sequencer driving a single-word I2C write engine
// Optional WM8731_CFG_VOL_EN adds runtime headphone-volume writes after the table.
module wm8731_cfg_seq
  import wm8731_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = 7'h1A,
  parameter int         GAP_CYCLES = 16,
  parameter bit         AUTO_START = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        i2c_idle,
`ifdef WM8731_CFG_VOL_EN
  input  logic        vol_wr,
  input  logic [6:0]  vol,
`endif
  output logic [23:0] din,
  output logic        wr_i2c,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [3:0]  idx
);

  localparam logic [3:0] LAST_IDX = 4'(TABLE_LEN - 1);

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [23:0] din_q, din_d;
  logic        wr_q, busy_q, done_q, err_q;
  logic [3:0]  ack_cnt_q, ack_cnt_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic        auto_q;
  logic        start_eff, gap_last, ack_last, seq_end;
  logic [15:0] rom_word, load_word;

  wm8731_cfg_rom u_rom (
    .idx_i  (idx_d),
    .word_o (rom_word)
  );

  // auto_q makes the first post-reset cycle look like a start request.
  assign start_eff = start | auto_q;
  assign gap_last  = (int'(gap_cnt_q) + 1 >= GAP_CYCLES);
  assign ack_last  = (int'(ack_cnt_q) + 1 >= ACK_TIMEOUT);

`ifdef WM8731_CFG_VOL_EN
  logic       vol_pend_q, vol_pend_d;
  logic [6:0] vol_val_q, vol_val_d;
  logic       vol_mode_q, vol_mode_d;
  logic [6:0] vol_src;

  assign vol_src   = vol_wr ? vol : vol_val_q;
  assign load_word = vol_mode_d ? reg_word(REG_LHPOUT, {2'b11, vol_src}) : rom_word;
  assign seq_end   = vol_mode_q || (idx_q == LAST_IDX);
`else
  assign load_word = rom_word;
  assign seq_end   = (idx_q == LAST_IDX);
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ack_cnt_d = '0;
    gap_cnt_d = '0;
`ifdef WM8731_CFG_VOL_EN
    vol_pend_d = vol_pend_q;
    vol_val_d  = vol_val_q;
    vol_mode_d = vol_mode_q;
    if (vol_wr && busy_q) begin
      vol_pend_d = 1'b1;
      vol_val_d  = vol;
    end
`endif
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_eff) begin
          state_d = S_LOAD;
          idx_d   = '0;
`ifdef WM8731_CFG_VOL_EN
          vol_mode_d = 1'b0;
        end else if (state_q == S_DONE && (vol_wr || vol_pend_q)) begin
          state_d    = S_LOAD;
          vol_mode_d = 1'b1;
          vol_pend_d = 1'b0;
`endif
        end
      end
      S_LOAD: if (i2c_idle) state_d = S_REQ;
      S_REQ:  state_d = S_ACK;
      S_ACK: begin
        if (!i2c_idle) state_d = S_BUSY;
        else if (ack_last) state_d = S_ERR;
        else ack_cnt_d = ack_cnt_q + 4'd1;
      end
      S_BUSY: if (i2c_idle) state_d = S_GAP;
      S_GAP: begin
        if (!gap_last) begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end else if (seq_end) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // din is captured on entry to S_LOAD so it is stable for the whole transaction.
  always_comb begin
    din_d = din_q;
    if (state_d == S_LOAD && state_q != S_LOAD) din_d = {DEV_ADDR, 1'b0, load_word};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      din_q     <= '0;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ack_cnt_q <= '0;
      gap_cnt_q <= '0;
      auto_q    <= AUTO_START;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      din_q     <= din_d;
      wr_q      <= (state_d == S_REQ);
      busy_q    <= (state_d inside {S_LOAD, S_REQ, S_ACK, S_BUSY, S_GAP});
      done_q    <= (state_d == S_DONE);
      err_q     <= (state_d == S_ERR);
      ack_cnt_q <= ack_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      auto_q    <= 1'b0;
    end
  end

`ifdef WM8731_CFG_VOL_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vol_pend_q <= 1'b0;
      vol_val_q  <= '0;
      vol_mode_q <= 1'b0;
    end else begin
      vol_pend_q <= vol_pend_d;
      vol_val_q  <= vol_val_d;
      vol_mode_q <= vol_mode_d;
    end
  end
`endif

  assign din    = din_q;
  assign wr_i2c = wr_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign idx    = idx_q;

endmodule

// File: doc/wm8731_cfg_seq.md
WM8731_CFG_SEQ -- requirements
Module: wm8731_cfg_seq

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h1A, the WM8731 7-bit I2C address.
REQ-002 SHALL have parameter GAP_CYCLES, default 16, the idle cycles between I2C transactions.
REQ-003 SHALL have parameter AUTO_START, default 1, which starts the sequence after reset release when 1.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-006 SHALL have port start, input, 1, a level request to run the init table.
REQ-007 SHALL have port i2c_idle, input, 1, from the I2C controller; 1 means the bus engine is idle.
REQ-008 SHALL have port din, output, 24, the word {DEV_ADDR, 1'b0, reg[6:0], data[8:0]} sent to the I2C controller.
REQ-009 SHALL have port wr_i2c, output, 1, a one-cycle transaction request.
REQ-010 SHALL have port busy, output, 1, which is high from table start until S_DONE or S_ERR.
REQ-011 SHALL have port done, output, 1, which is high in S_DONE.
REQ-012 SHALL have port err, output, 1, which is high in S_ERR.
REQ-013 SHALL have port idx, output, 4, the current table index.

Function
REQ-014 SHALL use FSM states S_IDLE, S_LOAD, S_REQ, S_ACK, S_BUSY, S_GAP, S_DONE and S_ERR, with all outputs registered.
REQ-015 SHALL transition S_IDLE, S_DONE or S_ERR to S_LOAD with idx=0 on start=1; start is ignored in all other states.
REQ-016 SHALL, in S_LOAD, load din from the table at idx and advance to S_REQ only when i2c_idle=1, otherwise stay in S_LOAD.
REQ-017 SHALL, in S_REQ, drive wr_i2c=1 for exactly one cycle, then go to S_ACK.
REQ-018 SHALL, in S_ACK, wait for i2c_idle=0 and go to S_BUSY; if i2c_idle is still 1 after 8 cycles, go to S_ERR.
REQ-019 SHALL, in S_BUSY, wait for i2c_idle=1, then go to S_GAP.
REQ-020 SHALL, in S_GAP, count GAP_CYCLES cycles, then go to S_DONE if idx==10, else increment idx and go to S_LOAD.
REQ-021 SHALL hold din constant from S_LOAD through the end of S_BUSY.
REQ-022 SHALL implement an 11-entry table, as reg:data pairs: R15:000, R0:017, R1:017, R2:079, R3:079, R4:012, R5:000, R6:000, R7:002, R8:000, R9:001.
REQ-023 SHALL treat S_ERR as sticky until reset or start, and SHALL hold idx at the failing entry while in S_ERR.

Reset
REQ-024 SHALL, on reset, force state S_IDLE, din=0, wr_i2c=0, busy=0, done=0, err=0, idx=0, and clear all counters and pending flags.
REQ-025 SHALL abandon any transaction in progress when reset is asserted mid-transaction, with no further wr_i2c.
REQ-026 SHALL, when AUTO_START=1, behave on the first cycle after reset deassertion exactly as if start=1.

Configuration
REQ-027 SHALL add inputs vol_wr (1) and vol (7) when WM8731_CFG_VOL_EN is defined.
REQ-028 SHALL, with WM8731_CFG_VOL_EN defined, run a vol_wr pulse seen in S_DONE as one transaction of R2 with data {1'b1, 1'b1, vol}, then return to S_DONE.
REQ-029 SHALL, with WM8731_CFG_VOL_EN defined, latch a vol_wr pulse seen while busy into a one-deep pending flag (latest vol wins) and serve it on reaching S_DONE.
REQ-030 SHALL, with WM8731_CFG_VOL_EN undefined, have neither vol port nor any volume logic.

Structure
REQ-031 SHALL place register address constants, the table length (11), the state encoding and the ACK timeout (8) in package wm8731_pkg.
REQ-032 SHALL implement the table as combinational sub-module wm8731_cfg_rom (idx in, 16-bit {reg, data} out).

Verification
REQ-033 SHALL verify: reset released, AUTO_START=1, I2C model idle -> first wr_i2c pulse with din=24'h341E00.
REQ-034 SHALL verify: full run with an I2C model busy 30 cycles per word -> 11 wr_i2c pulses, each 1 cycle, din sequence matching the table, done=1 after the last gap.
REQ-035 SHALL verify: model never drops i2c_idle on entry 3 -> err=1 on the 9th cycle after wr_i2c, idx=3, no further wr_i2c.
REQ-036 SHALL verify: reset asserted while in S_BUSY on entry 5 -> all outputs 0 the same cycle; sequence restarts at idx 0 after release.
REQ-037 SHALL verify, with WM8731_CFG_VOL_EN defined: vol_wr with vol=7'h60 in S_DONE -> a single wr_i2c with din=24'h3405E0, then done=1.
REQ-038 SHALL verify: start=1 held during the run -> no restart; start in S_ERR -> run restarts with idx=0, err=0.
